// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer
// Turns a single-cycle valid/ready request from the CPU MEM stage into a
// timed SRAM cycle: one setup cycle, a strobe of WAIT_CYCLES+1 cycles and one
// recovery cycle. Read data is captured at the end of the strobe and returned
// with a one-cycle resp_valid pulse. busy stalls the pipeline for the whole access.
module mem_access_sequencer #(
    parameter int WAIT_CYCLES = 1,   // extra strobe cycles beyond the first (0..15)
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,            // asynchronous, active low
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic [1:0]        mem_control,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dataWrite,
    input  logic [DATA_W-1:0] mem_dataRead
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ACCESS  = 2'd2,
        S_RECOVER = 2'd3
    } state_t;

    localparam logic [1:0] CTL_IDLE  = 2'b00;
    localparam logic [1:0] CTL_WRITE = 2'b01;
    localparam logic [1:0] CTL_READ  = 2'b10;

    // Strobe-length reload value; a 4-bit counter covers the 0..15 range.
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          ctl_q, ctl_d;
    logic                resp_valid_q, resp_valid_d;

    // State and registered outputs; reset forces the bus idle immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            ctl_q        <= CTL_IDLE;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ctl_q        <= ctl_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = WAIT_LD;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Last strobe cycle: read data is valid on the bus now.
                    if (!write_q) begin
                        rdata_d = mem_dataRead;
                    end
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobe only while in ACCESS; SETUP/RECOVER/IDLE keep the bus at 00,
        // so a read strobe and a write strobe are never adjacent.
        ctl_d        = (state_d == S_ACCESS) ? (write_q ? CTL_WRITE : CTL_READ) : CTL_IDLE;
        resp_valid_d = (state_d == S_RECOVER);
    end

    assign req_ready     = (state_q == S_IDLE);
    assign busy          = (state_q != S_IDLE);
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = rdata_q;
    assign mem_control   = ctl_q;
    assign mem_addr      = addr_q;
    assign mem_dataWrite = wdata_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: a schedule-based model (cycles since accept)
// predicts every output each cycle; directed sections pin literal values, and
// two extra instances cover the shortest and a longer strobe.
module tb_mem_access_sequencer;

    localparam int MW = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        req_ready, resp_valid, busy;
    logic [15:0] resp_rdata, mem_addr, mem_dataWrite;
    logic [1:0]  mem_control;
    logic [15:0] mem_dataRead = 16'hBEEF;
    logic        rand_rd = 1'b0;

    // secondary instances (WAIT_CYCLES = 0 and 3) share one request strobe
    logic        req2_valid = 1'b0;
    logic        r0_ready, r0_resp, r0_busy, r3_ready, r3_resp, r3_busy;
    logic [15:0] r0_rdata, r0_addr, r0_wdata, r3_rdata, r3_addr, r3_wdata;
    logic [1:0]  r0_ctl, r3_ctl;

    int checks = 0;
    int failures = 0;
    int txn_count = 0;

    always #5 clk = ~clk;

    mem_access_sequencer #(.WAIT_CYCLES(MW), .ADDR_W(16), .DATA_W(16)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy),
        .mem_control(mem_control), .mem_addr(mem_addr),
        .mem_dataWrite(mem_dataWrite), .mem_dataRead(mem_dataRead)
    );

    mem_access_sequencer #(.WAIT_CYCLES(0), .ADDR_W(16), .DATA_W(16)) u_w0 (
        .clk(clk), .rst(rst), .req_valid(req2_valid), .req_write(1'b0),
        .req_addr(16'h0042), .req_wdata(16'h0000), .req_ready(r0_ready),
        .resp_valid(r0_resp), .resp_rdata(r0_rdata), .busy(r0_busy),
        .mem_control(r0_ctl), .mem_addr(r0_addr),
        .mem_dataWrite(r0_wdata), .mem_dataRead(mem_dataRead)
    );

    mem_access_sequencer #(.WAIT_CYCLES(3), .ADDR_W(16), .DATA_W(16)) u_w3 (
        .clk(clk), .rst(rst), .req_valid(req2_valid), .req_write(1'b0),
        .req_addr(16'h0042), .req_wdata(16'h0000), .req_ready(r3_ready),
        .resp_valid(r3_resp), .resp_rdata(r3_rdata), .busy(r3_busy),
        .mem_control(r3_ctl), .mem_addr(r3_addr),
        .mem_dataWrite(r3_wdata), .mem_dataRead(mem_dataRead)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory read data: fixed 0xBEEF for the directed part, random afterwards.
    always @(negedge clk) mem_dataRead <= rand_rd ? 16'($urandom) : 16'hBEEF;

    // ---------------- behavioural model ----------------
    // m_age = cycles since the accepting edge (0 = idle). The access occupies
    // ages 1..MW+3: age 1 setup, ages 2..MW+2 strobe, age MW+3 recovery/response.
    int          m_age = 0;
    logic        m_write = 1'b0;
    logic [15:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_age   <= 0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_rdata <= '0;
        end else begin
            if (m_age == MW + 2 && !m_write) m_rdata <= mem_dataRead;
            if (m_age == 0) begin
                if (req_valid) begin
                    m_age   <= 1;
                    m_write <= req_write;
                    m_addr  <= req_addr;
                    m_wdata <= req_wdata;
                end
            end else if (m_age == MW + 3) begin
                m_age <= 0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [1:0] e_ctl;
    logic [1:0] prev_ctl = 2'b00;
    always @(negedge clk) begin
        e_ctl = (m_age >= 2 && m_age <= MW + 2) ? (m_write ? 2'b01 : 2'b10) : 2'b00;
        chk("ready", 32'(req_ready), 32'(m_age == 0));
        chk("busy", 32'(busy), 32'(m_age != 0));
        chk("mem_control", 32'(mem_control), 32'(e_ctl));
        chk("resp_valid", 32'(resp_valid), 32'(m_age == MW + 3));
        chk("resp_rdata", 32'(resp_rdata), 32'(m_rdata));
        chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("mem_dataWrite", 32'(mem_dataWrite), 32'(m_wdata));
        if (prev_ctl != 2'b00 && mem_control != 2'b00)
            chk("strobe_switch", 32'(mem_control), 32'(prev_ctl));
        prev_ctl <= mem_control;
        if (m_age == MW + 3) begin
            txn_count++;
            $display("txn %0d write=%0d addr=%04h wdata=%04h rdata=%04h", txn_count,
                     m_write, m_addr, m_wdata, resp_rdata);
        end
    end

    // Present a request and hold it until an edge where req_ready was 1.
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d);
        int  n;
        logic r;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        forever begin
            r = req_ready;
            @(posedge clk);
            if (r) break;
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=not_ready expected=ready t=%0t", $time);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(req_ready), 32'd1);
    endtask

    int c0_busy, c0_str, c0_resp, c3_busy, c3_str, c3_resp;

    initial begin
        // reset: req_ready decodes to 1 while held in reset
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_ctl", 32'(mem_control), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // directed read, WAIT_CYCLES=1: 00,10,10,00 then response
        do_req(1'b0, 16'h1234, 16'h0000);
        chk("rd_k1_ctl", 32'(mem_control), 32'd0);
        chk("rd_k1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rd_k2_ctl", 32'(mem_control), 32'd2);
        @(negedge clk);
        chk("rd_k3_ctl", 32'(mem_control), 32'd2);
        @(negedge clk);
        chk("rd_k4_ctl", 32'(mem_control), 32'd0);
        chk("rd_k4_resp", 32'(resp_valid), 32'd1);
        chk("rd_k4_rdata", 32'(resp_rdata), 32'hBEEF);
        chk("rd_k4_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("rd_k5_busy", 32'(busy), 32'd0);

        // directed write: addr/data stable, strobe 01 for two cycles, rdata kept
        do_req(1'b1, 16'h00FF, 16'hA5A5);
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge clk);
            chk("wr_addr", 32'(mem_addr), 32'h00FF);
            chk("wr_data", 32'(mem_dataWrite), 32'hA5A5);
            chk("wr_ctl", 32'(mem_control), (k == 2 || k == 3) ? 32'd1 : 32'd0);
        end
        chk("wr_resp", 32'(resp_valid), 32'd1);
        chk("wr_rdata_kept", 32'(resp_rdata), 32'hBEEF);
        @(negedge clk);

        // WAIT_CYCLES=0 and 3 instances: strobe 1/4 cycles, occupancy 3/6
        req2_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req2_valid = 1'b0;
        c0_busy = 0; c0_str = 0; c0_resp = 0; c3_busy = 0; c3_str = 0; c3_resp = 0;
        for (int i = 0; i < 9; i++) begin
            c0_busy += int'(r0_busy);
            c0_str  += int'(r0_ctl == 2'b10);
            c0_resp += int'(r0_resp);
            c3_busy += int'(r3_busy);
            c3_str  += int'(r3_ctl == 2'b10);
            c3_resp += int'(r3_resp);
            @(negedge clk);
        end
        chk("w0_strobe", 32'(c0_str), 32'd1);
        chk("w0_busy", 32'(c0_busy), 32'd3);
        chk("w0_resp", 32'(c0_resp), 32'd1);
        chk("w0_rdata", 32'(r0_rdata), 32'hBEEF);
        chk("w3_strobe", 32'(c3_str), 32'd4);
        chk("w3_busy", 32'(c3_busy), 32'd6);
        chk("w3_resp", 32'(c3_resp), 32'd1);
        chk("w3_rdata", 32'(r3_rdata), 32'hBEEF);

        // back-to-back: req_valid stays high from the read into the write
        rand_rd = 1'b1;
        do_req(1'b0, 16'($urandom), 16'($urandom));
        do_req(1'b1, 16'($urandom), 16'($urandom));
        wait_idle();

        // asynchronous reset in the middle of the strobe
        do_req(1'b0, 16'h4444, 16'h0000);
        @(negedge clk);
        chk("mid_ctl_before", 32'(mem_control), 32'd2);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ctl", 32'(mem_control), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_resp", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("post_rst_resp", 32'(resp_valid), 32'd0);
        end
        do_req(1'b0, 16'h0001, 16'h0000);
        wait_idle();

        // idle hold
        repeat (10) begin
            @(negedge clk);
            chk("idle_ctl", 32'(mem_control), 32'd0);
            chk("idle_resp", 32'(resp_valid), 32'd0);
            chk("idle_addr", 32'(mem_addr), 32'h0001);
        end

        // randomized traffic
        repeat (150) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_req(1'($urandom), 16'($urandom), 16'($urandom));
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Upstream sequencer that drives the SRAM memory interface block's control/addr/dataWrite inputs from CPU MEM-stage requests.
- Converts a single-cycle valid/ready request into a timed SRAM cycle (setup, strobe, recovery) with a programmable strobe width.
- Captures read data at the end of the strobe and returns it with a one-cycle response pulse.
- Asserts busy so the pipeline stalls for the whole access.

Parameters:
WAIT_CYCLES, 1, extra strobe cycles beyond the first; the strobe lasts WAIT_CYCLES+1 cycles; legal range 0..15.
ADDR_W, 16, request and memory address width.
DATA_W, 16, data width.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-low reset.
req_valid  in  1  CPU access request.
req_write  in  1  1=write, 0=read; sampled on accept.
req_addr  in  ADDR_W  access address; sampled on accept.
req_wdata  in  DATA_W  write data; sampled on accept.
req_ready  out  1  request can be accepted this cycle.
resp_valid  out  1  one-cycle pulse: access complete.
resp_rdata  out  DATA_W  read data; valid with resp_valid after a read.
busy  out  1  access in progress (pipeline stall).
mem_control  out  2  memory block control: 00 IDLE, 01 WRITE, 10 READ.
mem_addr  out  ADDR_W  memory block addr.
mem_dataWrite  out  DATA_W  memory block dataWrite.
mem_dataRead  in  DATA_W  memory block dataRead.

Behaviour:
- Reset (rst=0, asynchronous, immediate):
  - state=IDLE.
  - mem_control=00, mem_addr=0, mem_dataWrite=0.
  - resp_valid=0, resp_rdata=0, busy=0, counter=0.
  - req_ready is decoded from state, so it reads 1 during reset. It accepts nothing until the first clock edge after rst=1.
- States: IDLE, SETUP, ACCESS, RECOVER. All outputs are registered except req_ready=(state==IDLE) and busy=(state!=IDLE).
- IDLE:
  - mem_control=00.
  - On a clock edge with req_valid=1, latch req_write, req_addr and req_wdata into mem_addr and mem_dataWrite, then go to SETUP.
  - req_valid=0: stay; mem_addr and mem_dataWrite hold their last values.
- SETUP (1 cycle): mem_control=00 with addr and data stable. Load counter=WAIT_CYCLES, then go to ACCESS.
- ACCESS (WAIT_CYCLES+1 cycles):
  - mem_control=01 for a write, 10 for a read. Addr and data are held.
  - Counter decrements each cycle.
  - On the edge leaving ACCESS (counter==0), a read latches mem_dataRead into resp_rdata. A write leaves resp_rdata unchanged.
  - Then go to RECOVER.
- RECOVER (1 cycle):
  - mem_control=00, addr and data still held (hold time), resp_valid=1.
  - Next state is IDLE; resp_valid returns to 0.
- Latency: with accept on edge E0, resp_valid is high in the cycle after edge E0+WAIT_CYCLES+2.
  - Total occupancy is WAIT_CYCLES+3 cycles.
  - The earliest next accept is the first edge after RECOVER; req_ready is 0 in RECOVER.
- A request presented while busy is ignored. The requester must hold req_valid until the edge where req_ready=1.
- mem_control never switches directly between 01 and 10; at least one 00 cycle always separates strobes.
- An illegal or unreachable state goes to IDLE with mem_control=00.
- Reset mid-access: mem_control drops to 00 immediately and no resp_valid is produced for the aborted access.

Test Plan:
- Reset, then read, WAIT_CYCLES=1: rst low for 3 cycles, then high; req_valid=1, write=0, addr=0x1234; mem_dataRead model returns 0xBEEF.
  - mem_control sequence from the accept edge is 00,10,10,00.
  - resp_valid pulses once in the 4th cycle with resp_rdata=0xBEEF; busy is high for 4 cycles.
- Write: write=1, addr=0x00FF, wdata=0xA5A5.
  - mem_addr=0x00FF and mem_dataWrite=0xA5A5 are stable from SETUP through RECOVER; mem_control is 01 for exactly 2 cycles.
  - resp_rdata keeps its prior value (0xBEEF).
- Back-to-back: req_valid held high for a read then a write.
  - The second accept occurs only when req_ready=1 after RECOVER.
  - An IDLE cycle with mem_control=00 sits between the two strobes; there is never a 10→01 transition.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds: read strobe (10) lasts 1 and 4 cycles respectively; total occupancy is 3 and 6 cycles.
- Async reset mid-ACCESS: drop rst between clock edges.
  - mem_control=00, busy=0 and resp_valid=0 immediately, with no resp_valid afterwards.
  - After release, a new read to 0x0001 completes normally.
- Idle hold: req_valid=0 for 10 cycles; mem_control stays 00, resp_valid stays 0 and mem_addr is unchanged.
